// File: rtl/music_pkg.sv
// music_pkg: shared definitions for the music_player note sequencer.
// Holds the note code constants, the base-octave frequency table, the
// sequencer state enum and the half-period derivation used by note_period.
package music_pkg;

    // Note codes: 0..2 are rests, 3..14 are the twelve semitones of the base octave.
    localparam logic [5:0] NOTE_REST = 6'd0;
    localparam logic [5:0] NOTE_C    = 6'd3;
    localparam logic [5:0] NOTE_CS   = 6'd4;
    localparam logic [5:0] NOTE_D    = 6'd5;
    localparam logic [5:0] NOTE_DS   = 6'd6;
    localparam logic [5:0] NOTE_E    = 6'd7;
    localparam logic [5:0] NOTE_F    = 6'd8;
    localparam logic [5:0] NOTE_FS   = 6'd9;
    localparam logic [5:0] NOTE_G    = 6'd10;
    localparam logic [5:0] NOTE_GS   = 6'd11;
    localparam logic [5:0] NOTE_A    = 6'd12;
    localparam logic [5:0] NOTE_AS   = 6'd13;
    localparam logic [5:0] NOTE_B    = 6'd14;

    localparam int SEMITONES = 12;

    // C2..B2 frequencies in centi-Hz (C2 = 65.406 Hz -> 6541).
    localparam int BASE_FREQ_CHZ [SEMITONES] = '{
        6541, 6930, 7342, 7778, 8241, 8731,
        9250, 9800, 10383, 11000, 11654, 12347
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_PLAY,
        ST_GAP
    } state_t;

    // Half-period in clock cycles of semitone `semi` in the base octave:
    // floor(clk_hz / (2 * f)), with f in centi-Hz. Saturates at 24 bits.
    function automatic logic [23:0] base_half(input int clk_hz, input int semi);
        longint num;
        longint den;
        longint q;
        num = longint'(clk_hz) * 64'sd100;
        den = 64'sd2 * longint'(BASE_FREQ_CHZ[semi]);
        q   = num / den;
        if (q > 64'sd16777215) begin
            q = 64'sd16777215;
        end
        return q[23:0];
    endfunction

endpackage

// File: rtl/note_period.sv
// note_period: combinational decode of a 6-bit note code into a 24-bit
// tone half-period (clock cycles) plus a rest flag. Octave and semitone are
// split with a compare chain; the base-octave table is shifted per octave.
module note_period
    import music_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic [5:0]  note_code,
    output logic [23:0] half,
    output logic        rest
);

    logic [23:0] base_tbl [SEMITONES];
    logic [5:0]  pitch;
    logic [3:0]  semi;
    logic [2:0]  octave;
    logic [23:0] shifted;

    generate
        for (genvar gi = 0; gi < SEMITONES; gi++) begin : g_base
            assign base_tbl[gi] = base_half(CLK_HZ, gi);
        end
    endgenerate

    // Split the pitch index into octave and semitone without a divider
    always_comb begin
        pitch  = note_code - NOTE_C;
        octave = 3'd0;
        semi   = 4'(pitch);
        if (pitch >= 6'd60) begin
            octave = 3'd5;
            semi   = 4'(pitch - 6'd60);
        end else if (pitch >= 6'd48) begin
            octave = 3'd4;
            semi   = 4'(pitch - 6'd48);
        end else if (pitch >= 6'd36) begin
            octave = 3'd3;
            semi   = 4'(pitch - 6'd36);
        end else if (pitch >= 6'd24) begin
            octave = 3'd2;
            semi   = 4'(pitch - 6'd24);
        end else if (pitch >= 6'd12) begin
            octave = 3'd1;
            semi   = 4'(pitch - 6'd12);
        end
    end

    // Each octave up halves the period; a zero result is clamped to one cycle
    always_comb begin
        shifted = base_tbl[semi] >> octave;
        rest    = (note_code < NOTE_C);
        half    = (shifted == 24'd0) ? 24'd1 : shifted;
    end

endmodule

// File: rtl/music_player.sv
// music_player: steps through the note ROM, decodes each note and plays it
// as a square wave on the buzzer for NOTE_TICKS cycles, followed by a silent
// gap of GAP_TICKS cycles.
// Optional feature macro: MUSIC_PLAYER_LOOP_EN -- when defined, playback wraps
// from address 255 back to 0 forever; otherwise the sequencer stops in IDLE
// after address 255 and waits for play to fall and rise again.
module music_player
    import music_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int NOTE_TICKS = 25_000_000,
    parameter int GAP_TICKS  = 2_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       play,
    input  logic       rewind,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_note,
    output logic       buzzer,
    output logic [5:0] cur_note,
    output logic       note_strobe,
    output logic       playing
);

    localparam logic [31:0] NOTE_LAST = 32'(NOTE_TICKS - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_TICKS - 1);
    localparam logic [7:0]  ADDR_LAST = 8'd255;

    state_t      state_reg, state_next;
    logic [7:0]  addr_reg, addr_next;
    logic        buzzer_reg, buzzer_next;
    logic [5:0]  note_reg, note_next;
    logic        strobe_reg, strobe_next;
    logic [23:0] half_reg, half_next;
    logic        rest_reg, rest_next;
    logic [23:0] tone_reg, tone_next;
    logic [31:0] dur_reg, dur_next;
    // A rewind seen mid-note is remembered so the end-of-gap increment is skipped.
    logic        rew_pend_reg, rew_pend_next;
    // Set when playback ran off the end of the ROM; cleared once play drops.
    logic        done_reg, done_next;

    logic [23:0] dec_half;
    logic        dec_rest;
    logic [1:0]  rom_unused;

    // The two top bits of the ROM word carry no meaning for playback.
    assign rom_unused = rom_note[7:6];

    note_period #(
        .CLK_HZ (CLK_HZ)
    ) u_note_period (
        .note_code (rom_note[5:0]),
        .half      (dec_half),
        .rest      (dec_rest)
    );

    // State and datapath registers; reset returns to the silent idle state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= 8'd0;
            buzzer_reg   <= 1'b0;
            note_reg     <= 6'd0;
            strobe_reg   <= 1'b0;
            half_reg     <= 24'd1;
            rest_reg     <= 1'b0;
            tone_reg     <= 24'd0;
            dur_reg      <= 32'd0;
            rew_pend_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            buzzer_reg   <= buzzer_next;
            note_reg     <= note_next;
            strobe_reg   <= strobe_next;
            half_reg     <= half_next;
            rest_reg     <= rest_next;
            tone_reg     <= tone_next;
            dur_reg      <= dur_next;
            rew_pend_reg <= rew_pend_next;
            done_reg     <= done_next;
        end
    end

    // Sequencer next-state logic: fetch, load, play, gap, with pause and rewind
    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        buzzer_next   = buzzer_reg;
        note_next     = note_reg;
        strobe_next   = 1'b0;
        half_next     = half_reg;
        rest_next     = rest_reg;
        tone_next     = tone_reg;
        dur_next      = dur_reg;
        rew_pend_next = rew_pend_reg;
        done_next     = done_reg;

        case (state_reg)
            ST_IDLE: begin
                if (!play) begin
                    done_next = 1'b0;
                end else if (!done_reg) begin
                    state_next = ST_FETCH;
                end
            end

            default: begin
                if (!play) begin
                    // Pause: go silent, keep the address so the note restarts on resume.
                    state_next    = ST_IDLE;
                    buzzer_next   = 1'b0;
                    note_next     = 6'd0;
                    tone_next     = 24'd0;
                    dur_next      = 32'd0;
                    rew_pend_next = 1'b0;
                end else begin
                    rew_pend_next = rew_pend_reg | rewind;
                    case (state_reg)
                        ST_FETCH: begin
                            state_next = ST_LOAD;
                        end

                        ST_LOAD: begin
                            note_next   = rom_note[5:0];
                            strobe_next = 1'b1;
                            half_next   = dec_half;
                            rest_next   = dec_rest;
                            tone_next   = 24'd0;
                            dur_next    = 32'd0;
                            buzzer_next = 1'b0;
                            state_next  = ST_PLAY;
                        end

                        ST_PLAY: begin
                            if (tone_reg == half_reg - 24'd1) begin
                                tone_next = 24'd0;
                                if (!rest_reg) begin
                                    buzzer_next = ~buzzer_reg;
                                end
                            end else begin
                                tone_next = tone_reg + 24'd1;
                            end
                            if (dur_reg == NOTE_LAST) begin
                                dur_next    = 32'd0;
                                tone_next   = 24'd0;
                                buzzer_next = 1'b0;
                                state_next  = ST_GAP;
                            end else begin
                                dur_next = dur_reg + 32'd1;
                            end
                        end

                        ST_GAP: begin
                            buzzer_next = 1'b0;
                            if (dur_reg == GAP_LAST) begin
                                dur_next      = 32'd0;
                                rew_pend_next = 1'b0;
                                if (rew_pend_reg || rewind) begin
                                    addr_next  = 8'd0;
                                    state_next = ST_FETCH;
                                end else if (addr_reg == ADDR_LAST) begin
                                    addr_next = 8'd0;
`ifdef MUSIC_PLAYER_LOOP_EN
                                    state_next = ST_FETCH;
`else
                                    state_next = ST_IDLE;
                                    done_next  = 1'b1;
                                    note_next  = 6'd0;
`endif
                                end else begin
                                    addr_next  = addr_reg + 8'd1;
                                    state_next = ST_FETCH;
                                end
                            end else begin
                                dur_next = dur_reg + 32'd1;
                            end
                        end

                        default: begin
                            state_next = ST_IDLE;
                        end
                    endcase
                end
            end
        endcase

        // Rewind always wins over any address change made above.
        if (rewind) begin
            addr_next = 8'd0;
        end
    end

    assign rom_addr    = addr_reg;
    assign buzzer      = buzzer_reg;
    assign cur_note    = note_reg;
    assign note_strobe = strobe_reg;
    assign playing     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_music_player.sv
// tb_music_player: randomized and directed bench for music_player.
// A position-in-note reference model predicts every output each cycle; a
// second instance with very short notes is used to reach the end of the ROM.
`timescale 1ns/1ps
module tb_music_player;

    localparam int CLK_HZ = 1_000_000;
    localparam int NT     = 4000;
    localparam int GT     = 100;
    localparam int NT_W   = 4;
    localparam int GT_W   = 2;

    // C2..B2 in centi-Hz
    localparam int FCHZ [12] = '{6541, 6930, 7342, 7778, 8241, 8731,
                                 9250, 9800, 10383, 11000, 11654, 12347};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       play_m = 1'b0, rew_m = 1'b0, play_w = 1'b0, rew_w = 1'b0;
    logic [7:0] rom_addr_m, rom_note_m, rom_addr_w, rom_note_w;
    logic       buzzer_m, buzzer_w, strobe_m, strobe_w, playing_m, playing_w;
    logic [5:0] cur_note_m, cur_note_w;
    logic [7:0] rom_mem [256];

    int checks = 0;
    int errors = 0;
    bit wrap_done = 1'b0;

    always #5 clk = ~clk;

    music_player #(.CLK_HZ(CLK_HZ), .NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
        .clk(clk), .rst(rst), .play(play_m), .rewind(rew_m),
        .rom_addr(rom_addr_m), .rom_note(rom_note_m), .buzzer(buzzer_m),
        .cur_note(cur_note_m), .note_strobe(strobe_m), .playing(playing_m)
    );

    music_player #(.CLK_HZ(CLK_HZ), .NOTE_TICKS(NT_W), .GAP_TICKS(GT_W)) dut_w (
        .clk(clk), .rst(rst), .play(play_w), .rewind(rew_w),
        .rom_addr(rom_addr_w), .rom_note(rom_note_w), .buzzer(buzzer_w),
        .cur_note(cur_note_w), .note_strobe(strobe_w), .playing(playing_w)
    );

    // Behavioural note ROM, one-cycle registered read for each instance
    always @(posedge clk) begin
        rom_note_m <= rom_mem[rom_addr_m];
        rom_note_w <= rom_mem[rom_addr_w];
    end

    // Reference model: where we are inside the current note period
    // (0 = fetch, 1 = load, 2..nt+1 = tone, then gap) plus the address.
    typedef struct packed {
        bit         active;
        bit         pend;
        bit         done;
        bit         strobe;
        bit         rest;
        int         pos;
        int         addr;
        int         note;
        int         half;
        logic [7:0] latched;
    } model_t;

    model_t mm, mw;

    function automatic int model_half(input int code);
        int     p;
        longint h;
        p = code - 3;
        h = (longint'(CLK_HZ) * 100) / (2 * longint'(FCHZ[p % 12]));
        h = h >> (p / 12);
        if (h == 0) h = 1;
        return int'(h);
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r = '0;
        r.half = 1;
        return r;
    endfunction

    function automatic model_t model_step(input model_t m, input bit ply, input bit rew,
                                          input int nt, input int gt);
        model_t r;
        r = m;
        r.strobe = 1'b0;
        if (!m.active) begin
            if (!ply) r.done = 1'b0;
            else if (!m.done) begin
                r.active = 1'b1;
                r.pos = 0;
            end
            if (rew) r.addr = 0;
        end else if (!ply) begin
            r.active = 1'b0;
            r.note = 0;
            r.pend = 1'b0;
            r.pos = 0;
            if (rew) r.addr = 0;
        end else if (m.pos == nt + gt + 1) begin
            r.pos = 0;
            r.pend = 1'b0;
            if (m.pend || rew || m.addr == 255) r.addr = 0;
            else r.addr = m.addr + 1;
`ifndef MUSIC_PLAYER_LOOP_EN
            if (!m.pend && !rew && m.addr == 255) begin
                r.active = 1'b0;
                r.done = 1'b1;
                r.note = 0;
            end
`endif
        end else begin
            r.pos = m.pos + 1;
            if (m.pos == 0) r.latched = rom_mem[m.addr];
            if (m.pos == 1) begin
                r.note = int'(m.latched[5:0]);
                r.strobe = 1'b1;
                r.rest = (r.note < 3);
                if (!r.rest) r.half = model_half(r.note);
            end
            if (rew) begin
                r.addr = 0;
                r.pend = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic bit exp_buzzer(input model_t m, input int nt);
        if (!m.active || m.rest || m.pos < 2 || m.pos >= nt + 2) return 1'b0;
        return (((m.pos - 2) / m.half) % 2) == 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_dut(input string pfx, input model_t m, input int nt,
                               input logic [7:0] addr, input logic bz, input logic [5:0] note,
                               input logic stb, input logic ply);
        check({pfx, "_rom_addr"}, 32'(addr), 32'(m.addr));
        check({pfx, "_buzzer"}, 32'(bz), 32'(exp_buzzer(m, nt)));
        check({pfx, "_cur_note"}, 32'(note), 32'(m.note));
        check({pfx, "_note_strobe"}, 32'(stb), 32'(m.strobe));
        check({pfx, "_playing"}, 32'(ply), 32'(m.active));
    endtask

    // Compare process: advance both models on each edge, check 1 ns later
    always @(posedge clk) begin
        if (rst) begin
            mm = model_reset();
            mw = model_reset();
        end else begin
            mm = model_step(mm, play_m, rew_m, NT, GT);
            mw = model_step(mw, play_w, rew_w, NT_W, GT_W);
        end
        #1;
        compare_dut("main", mm, NT, rom_addr_m, buzzer_m, cur_note_m, strobe_m, playing_m);
        compare_dut("wrap", mw, NT_W, rom_addr_w, buzzer_w, cur_note_w, strobe_w, playing_w);
    end

    task automatic bound_fail(input string name, input bit timed_out);
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL %s: timed out, expected event", name);
        end
    endtask

    task automatic wait_strobe_m(input string name, input int limit);
        int n = 0;
        while (strobe_m !== 1'b1 && n < limit) begin
            @(posedge clk); #2;
            n++;
        end
        bound_fail(name, n >= limit);
    endtask

    task automatic wait_addr_m(input string name, input int val, input int limit);
        int n = 0;
        while (rom_addr_m !== 8'(val) && n < limit) begin
            @(posedge clk); #2;
            n++;
        end
        bound_fail(name, n >= limit);
    endtask

    // Run the short-note instance through the whole ROM to the wrap point
    task automatic wrap_run();
        int n = 0;
        play_w = 1'b1;
        while (rom_addr_w !== 8'd255 && n < 4000) begin
            @(posedge clk); #2;
            n++;
        end
        bound_fail("wrap_reach_255", n >= 4000);
        n = 0;
        while (rom_addr_w === 8'd255 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        check("wrap_addr", 32'(rom_addr_w), 32'd0);
`ifdef MUSIC_PLAYER_LOOP_EN
        check("wrap_playing", 32'(playing_w), 32'd1);
`else
        check("wrap_playing", 32'(playing_w), 32'd0);
        repeat (20) @(posedge clk);
        #2;
        check("wrap_stays_idle", 32'(playing_w), 32'd0);
`endif
        play_w = 1'b0;
        @(posedge clk); #2;
        play_w = 1'b1;
        @(posedge clk); #2;
        check("wrap_restart", 32'(playing_w), 32'd1);
        wrap_done = 1'b1;
    endtask

    initial begin
        int highs;
        int n;
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
        rom_mem[0] = 8'd48;   // A5, 880 Hz -> half 568 at 1 MHz
        rom_mem[1] = 8'hC0;   // code 0 with junk in the ignored bits: rest
        rom_mem[5] = 8'h4F;   // code 15
        rom_mem[7] = 8'd20;

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #2;
        check("reset_rom_addr", 32'(rom_addr_m), 32'd0);
        check("reset_playing", 32'(playing_m), 32'd0);
        check("reset_buzzer", 32'(buzzer_m), 32'd0);
        check("reset_cur_note", 32'(cur_note_m), 32'd0);
        check("reset_strobe", 32'(strobe_m), 32'd0);

        fork
            wrap_run();
        join_none

        // Tone pitch: strobe after fetch+load, then 568-cycle half periods
        play_m = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("first_strobe", 32'(strobe_m), 32'd1);
        check("first_note", 32'(cur_note_m), 32'd48);
        n = 0;
        while (buzzer_m === 1'b0 && n < 2000) begin @(posedge clk); #2; n++; end
        check("first_toggle", 32'(n), 32'd568);
        n = 0;
        while (buzzer_m === 1'b1 && n < 2000) begin @(posedge clk); #2; n++; end
        check("second_toggle", 32'(n), 32'd568);

        // Rest note at address 1
        wait_strobe_m("rest_strobe_wait", 5000);
        check("rest_note", 32'(cur_note_m), 32'd0);
        highs = 0;
        repeat (4090) begin
            @(posedge clk); #2;
            highs += int'(buzzer_m);
        end
        check("rest_silent", 32'(highs), 32'd0);
        n = 0;
        while (rom_addr_m === 8'd1 && n < 50) begin @(posedge clk); #2; n++; end
        check("after_rest_addr", 32'(rom_addr_m), 32'd2);

        // Pause mid-note at address 5, then resume
        wait_addr_m("addr5_wait", 5, 13000);
        wait_strobe_m("addr5_strobe_wait", 10);
        repeat (1000) @(posedge clk);
        #2 play_m = 1'b0;
        @(posedge clk); #2;
        check("pause_playing", 32'(playing_m), 32'd0);
        check("pause_addr", 32'(rom_addr_m), 32'd5);
        check("pause_note", 32'(cur_note_m), 32'd0);
        repeat (5) @(posedge clk);
        #2 play_m = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("resume_strobe", 32'(strobe_m), 32'd1);
        check("resume_note", 32'(cur_note_m), 32'd15);

        // Rewind during the gap of address 7
        wait_addr_m("addr7_wait", 7, 9000);
        wait_strobe_m("addr7_strobe_wait", 10);
        repeat (4010) @(posedge clk);
        #2 rew_m = 1'b1;
        @(posedge clk); #2;
        rew_m = 1'b0;
        check("rewind_addr", 32'(rom_addr_m), 32'd0);
        wait_strobe_m("rewind_strobe_wait", 200);
        check("rewind_note", 32'(cur_note_m), 32'd48);
        check("rewind_fetch_addr", 32'(rom_addr_m), 32'd0);
        n = 0;
        while (rom_addr_m === 8'd0 && n < 4300) begin @(posedge clk); #2; n++; end
        check("rewind_next_addr", 32'(rom_addr_m), 32'd1);

        // Random pauses and rewinds checked cycle by cycle by the model
        for (int c = 0; c < 30000; c++) begin
            @(posedge clk); #2;
            rew_m = ($urandom_range(0, 1999) == 0);
            if (play_m) begin
                if ($urandom_range(0, 2999) == 0) play_m = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                play_m = 1'b1;
            end
        end
        rew_m = 1'b0;
        play_m = 1'b1;

        // Asynchronous reset in the middle of a note
        wait_strobe_m("reset_strobe_wait", 6000);
        repeat (700) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midplay_rst_buzzer", 32'(buzzer_m), 32'd0);
        check("midplay_rst_note", 32'(cur_note_m), 32'd0);
        check("midplay_rst_playing", 32'(playing_m), 32'd0);
        check("midplay_rst_addr", 32'(rom_addr_m), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (10) @(posedge clk);
        #2;

        n = 0;
        while (!wrap_done && n < 100) begin @(posedge clk); #2; n++; end
        bound_fail("wrap_done_wait", !wrap_done);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
